// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// Holds the state encoding, opcode/funct constants and ALUControl codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_TRAP     = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master: the controller (reads instruction fields and mem_ready, drives
// every select/enable); slave: the datapath side.
interface multicycle_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       Bgtz;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  Op, Funct, mem_ready,
    output IorD, MemWrite, IRWrite, PCWrite, Branch, Bgtz, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite,
           instr_done, illegal
  );

  modport slave (
    output Op, Funct, mem_ready,
    input  IorD, MemWrite, IRWrite, PCWrite, Branch, Bgtz, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite,
           instr_done, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct decoder (combinational).
// Ports: funct in (Instr[5:0]); alu_control out (ALU op code);
// legal out (funct is one of add/sub/and/or/slt).
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core.
// Ports: clk, rst_n (async active-low); bus (master modport) carries
// Op/Funct/mem_ready in and all datapath selects/enables, instr_done and
// illegal out.
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4 (waits for mem_ready)
// DECODE    | precompute branch target, dispatch on Op
// MEMADR    | compute A + SignImm for lw/sw
// MEMREAD   | read data memory (waits for mem_ready)
// MEMWB     | write MDR to rt
// MEMWRITE  | write data memory (waits for mem_ready)
// EXECUTE   | R-type ALU op
// ALUWB     | write ALUOut to rd
// BRANCH    | compare and conditionally load PC (beq/bgtz)
// ADDIEX    | A + SignImm
// ADDIWB    | write ALUOut to rt
// JUMP      | load jump target
// TRAP      | illegal instruction, skip it
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_if.master        bus
);

  state_t     state;
  logic [2:0] funct_alu;
  logic       funct_legal;

  alu_decoder u_alu_decoder (
    .funct       (bus.Funct),
    .alu_control (funct_alu),
    .legal       (funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.Op)
            OP_LW, OP_SW:    state <= S_MEMADR;
            OP_RTYPE:        state <= funct_legal ? S_EXECUTE : S_TRAP;
            OP_BEQ, OP_BGTZ: state <= S_BRANCH;
            OP_ADDI:         state <= S_ADDIEX;
            OP_J:            state <= S_JUMP;
            default:         state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= (bus.Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
        S_EXECUTE:  state <= S_ALUWB;
        S_ADDIEX:   state <= S_ADDIWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode straight from the state register; rst_n gates them so a
  // write in flight (MemWrite) drops the instant reset is asserted.
  always_comb begin
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.Bgtz       = 1'b0;
    bus.PCSrc      = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 3'b000;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          bus.ALUSrcB    = 2'b01;
          bus.ALUControl = ALU_ADD;
          bus.IRWrite    = bus.mem_ready;
          bus.PCWrite    = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB    = 2'b11;
          bus.ALUControl = ALU_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUSrcB    = 2'b10;
          bus.ALUControl = ALU_ADD;
        end
        S_MEMREAD: bus.IorD = 1'b1;
        S_MEMWB: begin
          bus.MemtoReg   = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          bus.IorD       = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        S_EXECUTE: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = funct_alu;
        end
        S_ALUWB: begin
          bus.RegDst     = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = ALU_SUB;
          bus.PCSrc      = 2'b01;
          bus.Branch     = (bus.Op == OP_BEQ);
          bus.Bgtz       = (bus.Op == OP_BGTZ);
          bus.instr_done = 1'b1;
        end
        S_ADDIWB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_JUMP: begin
          bus.PCSrc      = 2'b10;
          bus.PCWrite    = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_TRAP: begin
          bus.illegal    = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
